// File: rtl/led_seq_pkg.sv
// LED sequencer shared definitions.
// State encoding, table entry layout and reset defaults.
package led_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    // Table entry layout: {dwell, speed[1:0], dir, mode, color[2:0]}
    localparam int COLOR_LSB = 0;
    localparam int COLOR_W   = 3;
    localparam int MODE_BIT  = 3;
    localparam int DIR_BIT   = 4;
    localparam int SPEED_LSB = 5;
    localparam int SPEED_W   = 2;
    localparam int DWELL_LSB = 7;
    localparam int CFG_W     = 7;

    // Reset configuration: color 001, everything else zero
    localparam logic [CFG_W-1:0] DEF_CFG   = 7'b000_0001;
    localparam logic [2:0]       DEF_COLOR = 3'b001;
    localparam int               DEF_DWELL = 4;

    // Button masks into the rising-edge vector
    localparam logic [3:0] BTN_START_M   = 4'b0001;
    localparam logic [3:0] BTN_SKIP_M    = 4'b0010;
    localparam logic [3:0] BTN_RESTART_M = 4'b0100;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Configuration handshake toward the shift-LED datapath.
// The sequencer is master, the datapath is slave.
interface led_seq_ctrl_if;

    logic [2:0] cfg_color;
    logic       cfg_mode;
    logic       cfg_dir;
    logic [1:0] cfg_speed;
    logic       cfg_valid;
    logic       cfg_ready;

    modport master (
        output cfg_color,
        output cfg_mode,
        output cfg_dir,
        output cfg_speed,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_color,
        input  cfg_mode,
        input  cfg_dir,
        input  cfg_speed,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/led_seq_ctrl_btn_edge.sv
// Registered rising-edge detector for the four raw buttons.
// History and pulses are frozen while i_en is low.
module btn_edge (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_en,
    input  logic [3:0] i_btn,
    output logic [3:0] o_rise
);

    logic [3:0] r_prev;

    // Remember last sampled button levels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= 4'b0000;
        end else if (i_en) begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_en ? (i_btn & ~r_prev) : 4'b0000;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED program sequencer: steps through a small table of
// datapath configurations, each held for a dwell time in ticks.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int NB_PRESCALE = 24,
    parameter int NB_DWELL    = 5,
    parameter int N_STEPS     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_enable,
    input  logic [3:0]                 i_btn,
    input  logic                       i_wr_en,
    input  logic [$clog2(N_STEPS)-1:0] i_wr_addr,
    input  logic [CFG_W+NB_DWELL-1:0]  i_wr_data,
    led_seq_ctrl_if.master             cfg_if,
    output logic [1:0]                 o_state,
    output logic [$clog2(N_STEPS)-1:0] o_step,
    output logic                       o_tick
);

    localparam int AW  = $clog2(N_STEPS);
    localparam int EW  = CFG_W + NB_DWELL;
    localparam int DCW = NB_DWELL + 1;

    localparam logic [EW-1:0] DEF_ENTRY =
        {NB_DWELL'(DEF_DWELL), DEF_CFG};

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [AW-1:0]          r_step;
    logic [AW-1:0]          w_step_nx;
    logic [NB_PRESCALE-1:0] r_presc;
    logic [NB_PRESCALE-1:0] w_presc_nx;
    logic [DCW-1:0]         r_dwell;
    logic [DCW-1:0]         w_dwell_nx;
    logic [DCW-1:0]         w_dwell_load;
    logic                   r_valid;
    logic                   w_valid_nx;
    logic                   w_capture;
    logic                   w_tick;

    logic [2:0]             r_color;
    logic                   r_mode;
    logic                   r_dir;
    logic [1:0]             r_speed;
    logic [NB_DWELL-1:0]    r_dwell_cap;

    logic [EW-1:0]          r_table [N_STEPS];
    logic [EW-1:0]          w_entry;

    logic [3:0]             w_rise;
    logic                   w_start;
    logic                   w_skip;
    logic                   w_restart;

    btn_edge u_btn_edge (
        .clock  (clock),
        .reset  (reset),
        .i_en   (i_enable),
        .i_btn  (i_btn),
        .o_rise (w_rise)
    );

    assign w_start   = |(w_rise & BTN_START_M);
    assign w_skip    = |(w_rise & BTN_SKIP_M);
    assign w_restart = |(w_rise & BTN_RESTART_M);

    assign w_entry = r_table[r_step];

    // A stored dwell of zero stands for the full 2**NB_DWELL ticks
    assign w_dwell_load = (r_dwell_cap == '0)
                        ? {1'b1, {NB_DWELL{1'b0}}}
                        : {1'b0, r_dwell_cap};

    // Next-state, counter and handshake decisions
    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_presc_nx = r_presc;
        w_dwell_nx = r_dwell;
        w_valid_nx = r_valid;
        w_capture  = 1'b0;
        w_tick     = 1'b0;
        if (i_enable) begin
            if (w_restart && (r_state != S_IDLE)) begin
                w_state_nx = S_LOAD;
                w_step_nx  = '0;
                w_valid_nx = 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            w_state_nx = S_LOAD;
                            w_step_nx  = '0;
                        end
                    end
                    S_LOAD: begin
                        if (!r_valid) begin
                            w_capture  = 1'b1;
                            w_valid_nx = 1'b1;
                        end else if (cfg_if.cfg_ready) begin
                            w_state_nx = S_RUN;
                            w_valid_nx = 1'b0;
                            w_dwell_nx = w_dwell_load;
                            w_presc_nx = '0;
                        end
                    end
                    S_RUN: begin
                        if (w_start) begin
                            w_state_nx = S_PAUSE;
                        end else if (w_skip) begin
                            w_step_nx  = r_step + 1'b1;
                            w_state_nx = S_LOAD;
                        end else begin
                            w_presc_nx = r_presc + 1'b1;
                            if (&r_presc) begin
                                w_tick = 1'b1;
                                if (r_dwell == DCW'(1)) begin
                                    w_step_nx  = r_step + 1'b1;
                                    w_state_nx = S_LOAD;
                                end else begin
                                    w_dwell_nx = r_dwell - 1'b1;
                                end
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (w_start) begin
                            w_state_nx = S_RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM, step, prescaler, dwell and valid registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_presc <= '0;
            r_dwell <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
            r_presc <= w_presc_nx;
            r_dwell <= w_dwell_nx;
            r_valid <= w_valid_nx;
        end
    end

    // Latch the current step's entry while valid is low in LOAD
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_color     <= DEF_COLOR;
            r_mode      <= 1'b0;
            r_dir       <= 1'b0;
            r_speed     <= 2'b00;
            r_dwell_cap <= NB_DWELL'(DEF_DWELL);
        end else if (w_capture) begin
            r_color     <= w_entry[COLOR_LSB +: COLOR_W];
            r_mode      <= w_entry[MODE_BIT];
            r_dir       <= w_entry[DIR_BIT];
            r_speed     <= w_entry[SPEED_LSB +: SPEED_W];
            r_dwell_cap <= w_entry[DWELL_LSB +: NB_DWELL];
        end
    end

    // Program table, writable in any state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_STEPS; i++) begin
                r_table[i] <= DEF_ENTRY;
            end
        end else if (i_wr_en) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    assign cfg_if.cfg_color = r_color;
    assign cfg_if.cfg_mode  = r_mode;
    assign cfg_if.cfg_dir   = r_dir;
    assign cfg_if.cfg_speed = r_speed;
    assign cfg_if.cfg_valid = r_valid;

    assign o_state = r_state;
    assign o_step  = r_step;
    assign o_tick  = w_tick;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl: directed scenarios plus a random
// run checked against a cycle-count based reference model.
module tb_led_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_enable;
    logic [3:0]  i_btn;
    logic        i_wr_en;
    logic [1:0]  i_wr_addr;
    logic [11:0] i_wr_data;
    logic [1:0]  o_state;
    logic [1:0]  o_step;
    logic        o_tick;

    led_seq_ctrl_if cfg_if ();

    led_seq_ctrl #(
        .NB_PRESCALE (2),
        .NB_DWELL    (5),
        .N_STEPS     (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_enable  (i_enable),
        .i_btn     (i_btn),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .cfg_if    (cfg_if),
        .o_state   (o_state),
        .o_step    (o_step),
        .o_tick    (o_tick)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: states 0..3 = idle/load/run/pause
    int          m_state;
    int          m_step;
    int          m_elapsed;
    int          m_len;
    bit          m_valid;
    bit          m_tick;
    logic [11:0] m_cfg;
    logic [11:0] m_table [4];
    logic [3:0]  m_prev;
    logic        act_tick;

    task mdl_reset();
        m_state   = 0;
        m_step    = 0;
        m_elapsed = 0;
        m_len     = 0;
        m_valid   = 0;
        m_tick    = 0;
        m_cfg     = 12'h201;
        m_prev    = 4'b0000;
        for (int i = 0; i < 4; i++) m_table[i] = 12'h201;
    endtask

    // One clock of spec behaviour, using the currently driven inputs
    task mdl_advance();
        logic [3:0] e;
        int dw;
        m_tick = 0;
        if (i_enable) begin
            e = i_btn & ~m_prev;
            m_prev = i_btn;
            if (e[2] && m_state != 0) begin
                m_state = 1;
                m_step  = 0;
                m_valid = 0;
            end else begin
                case (m_state)
                    0: if (e[0]) begin
                        m_state = 1;
                        m_step  = 0;
                    end
                    1: if (!m_valid) begin
                        m_cfg   = m_table[m_step];
                        m_valid = 1;
                    end else if (cfg_if.cfg_ready) begin
                        dw = int'(m_cfg[11:7]);
                        if (dw == 0) dw = 32;
                        m_len     = 4 * dw;
                        m_elapsed = 0;
                        m_state   = 2;
                        m_valid   = 0;
                    end
                    2: if (e[0]) begin
                        m_state = 3;
                    end else if (e[1]) begin
                        m_step  = (m_step + 1) % 4;
                        m_state = 1;
                    end else begin
                        m_tick = (m_elapsed % 4 == 3);
                        m_elapsed++;
                        if (m_elapsed == m_len) begin
                            m_step  = (m_step + 1) % 4;
                            m_state = 1;
                        end
                    end
                    3: if (e[0]) m_state = 2;
                    default: ;
                endcase
            end
        end
        if (i_wr_en) m_table[i_wr_addr] = i_wr_data;
    endtask

    task clk_step();
        @(negedge clock);
        mdl_advance();
        act_tick = o_tick;
        @(posedge clock);
        #1;
    endtask

    task press(input int b);
        i_btn[b] = 1'b1;
        clk_step();
        i_btn[b] = 1'b0;
        clk_step();
    endtask

    function automatic logic [11:0] dut_snap();
        return {o_state, o_step, cfg_if.cfg_valid,
                cfg_if.cfg_speed, cfg_if.cfg_dir,
                cfg_if.cfg_mode, cfg_if.cfg_color};
    endfunction

    function automatic logic [11:0] mdl_snap();
        return {2'(m_state), 2'(m_step), m_valid, m_cfg[6:0]};
    endfunction

    task test_reset();
        reset = 1'b1;
        i_enable = 1'b1;
        i_btn = 4'b0000;
        i_wr_en = 1'b0;
        i_wr_addr = 2'd0;
        i_wr_data = 12'h000;
        cfg_if.cfg_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (dut_snap() !== 12'b00_00_0_00_0_0_001) begin
            errors++;
            $display("FAIL reset_state got %h want %h",
                     dut_snap(), 12'b00_00_0_00_0_0_001);
        end
        checks++;
        if (o_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got %b want 0", o_tick);
        end
        reset = 1'b0;
        mdl_reset();
        press(1);
        press(2);
        press(3);
        checks++;
        if (o_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_ignore got %0d want 0", o_state);
        end
    endtask

    task test_basic();
        int n;
        int ticks;
        press(0);
        checks++;
        if ({o_state, cfg_if.cfg_valid, cfg_if.cfg_color}
            !== {2'd1, 1'b1, 3'b001}) begin
            errors++;
            $display("FAIL load_offer got %0d/%b/%b want 1/1/001",
                     o_state, cfg_if.cfg_valid, cfg_if.cfg_color);
        end
        clk_step();
        checks++;
        if ({o_state, cfg_if.cfg_valid} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL run_enter got %0d/%b want 2/0",
                     o_state, cfg_if.cfg_valid);
        end
        n = 0;
        ticks = 0;
        while (o_state == 2'd2 && n < 200) begin
            clk_step();
            n++;
            ticks += int'(act_tick);
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL step0_len got %0d want 16", n);
        end
        checks++;
        if (ticks !== 4) begin
            errors++;
            $display("FAIL step0_ticks got %0d want 4", ticks);
        end
        checks++;
        if ({o_state, o_step} !== {2'd1, 2'd1}) begin
            errors++;
            $display("FAIL step_adv got %0d/%0d want 1/1",
                     o_state, o_step);
        end
    endtask

    task test_dwell_zero();
        int n;
        i_wr_en = 1'b1;
        i_wr_addr = 2'd3;
        i_wr_data = {5'd0, 7'b1010110};
        clk_step();
        i_wr_en = 1'b0;
        n = 0;
        while (!(o_state == 2'd2 && o_step == 2'd3) && n < 500) begin
            clk_step();
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL reach_step3 got timeout want run step 3");
        end
        checks++;
        if (dut_snap() !== {2'd2, 2'd3, 1'b0, 7'b1010110}) begin
            errors++;
            $display("FAIL step3_cfg got %h want %h", dut_snap(),
                     {2'd2, 2'd3, 1'b0, 7'b1010110});
        end
        n = 0;
        while (o_state == 2'd2 && n < 400) begin
            clk_step();
            n++;
        end
        checks++;
        if (n !== 128) begin
            errors++;
            $display("FAIL dwell0_len got %0d want 128", n);
        end
        checks++;
        if (o_step !== 2'd0) begin
            errors++;
            $display("FAIL wrap got %0d want 0", o_step);
        end
    endtask

    task test_ready_stall();
        logic [11:0] snap0;
        cfg_if.cfg_ready = 1'b0;
        clk_step();
        snap0 = dut_snap();
        checks++;
        if (snap0 !== {2'd1, 2'd0, 1'b1, 7'h01}) begin
            errors++;
            $display("FAIL stall_offer got %h want %h", snap0,
                     {2'd1, 2'd0, 1'b1, 7'h01});
        end
        for (int k = 0; k < 10; k++) begin
            clk_step();
            checks++;
            if (dut_snap() !== snap0) begin
                errors++;
                $display("FAIL stall_hold got %h want %h",
                         dut_snap(), snap0);
            end
        end
        cfg_if.cfg_ready = 1'b1;
        clk_step();
        checks++;
        if (o_state !== 2'd2) begin
            errors++;
            $display("FAIL stall_release got %0d want 2", o_state);
        end
    endtask

    task test_pause();
        int n;
        repeat (8) clk_step();
        i_btn[0] = 1'b1;
        clk_step();
        i_btn[0] = 1'b0;
        repeat (50) clk_step();
        checks++;
        if ({o_state, o_step} !== {2'd3, 2'd0}) begin
            errors++;
            $display("FAIL paused got %0d/%0d want 3/0",
                     o_state, o_step);
        end
        i_btn[0] = 1'b1;
        clk_step();
        i_btn[0] = 1'b0;
        n = 0;
        while (o_state == 2'd2 && n < 100) begin
            clk_step();
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL resume_len got %0d want 8", n);
        end
        checks++;
        if (o_step !== 2'd1) begin
            errors++;
            $display("FAIL resume_step got %0d want 1", o_step);
        end
    endtask

    task test_restart_skip();
        int n;
        n = 0;
        while (!(o_state == 2'd2 && o_step == 2'd2) && n < 100) begin
            clk_step();
            n++;
        end
        repeat (3) clk_step();
        i_btn = 4'b0110;
        clk_step();
        i_btn = 4'b0000;
        checks++;
        if ({o_state, o_step, cfg_if.cfg_valid}
            !== {2'd1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_skip got %0d/%0d/%b want 1/0/0",
                     o_state, o_step, cfg_if.cfg_valid);
        end
        cfg_if.cfg_ready = 1'b0;
        clk_step();
        i_btn = 4'b0100;
        clk_step();
        i_btn = 4'b0000;
        checks++;
        if ({o_state, o_step, cfg_if.cfg_valid}
            !== {2'd1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_drop got %0d/%0d/%b want 1/0/0",
                     o_state, o_step, cfg_if.cfg_valid);
        end
        clk_step();
        checks++;
        if (dut_snap() !== {2'd1, 2'd0, 1'b1, 7'h01}) begin
            errors++;
            $display("FAIL abort_reoffer got %h want %h",
                     dut_snap(), {2'd1, 2'd0, 1'b1, 7'h01});
        end
        cfg_if.cfg_ready = 1'b1;
    endtask

    task test_enable();
        logic [11:0] snap0;
        int n;
        clk_step();
        repeat (5) clk_step();
        snap0 = dut_snap();
        i_enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            i_btn[0] = (k == 7);
            clk_step();
            checks++;
            if ({dut_snap(), act_tick} !== {snap0, 1'b0}) begin
                errors++;
                $display("FAIL freeze got %h/%b want %h/0",
                         dut_snap(), act_tick, snap0);
            end
        end
        i_btn = 4'b0000;
        i_enable = 1'b1;
        n = 0;
        while (o_state == 2'd2 && n < 100) begin
            clk_step();
            n++;
        end
        checks++;
        if ({n, o_step} !== {32'd11, 2'd1}) begin
            errors++;
            $display("FAIL unfreeze got %0d/%0d want 11/1", n, o_step);
        end
    endtask

    task test_async_reset();
        int n;
        cfg_if.cfg_ready = 1'b0;
        n = 0;
        while (!(o_state == 2'd1 && cfg_if.cfg_valid) && n < 50) begin
            clk_step();
            n++;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_state, cfg_if.cfg_valid} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL arst_load got %0d/%b want 0/0",
                     o_state, cfg_if.cfg_valid);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        mdl_reset();
        cfg_if.cfg_ready = 1'b1;
        press(0);
        clk_step();
        repeat (3) clk_step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_snap() !== 12'b00_00_0_00_0_0_001) begin
            errors++;
            $display("FAIL arst_run got %h want %h", dut_snap(),
                     12'b00_00_0_00_0_0_001);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        mdl_reset();
    endtask

    task test_random();
        for (int c = 0; c < 5000; c++) begin
            i_enable = ($urandom_range(0, 9) != 0);
            i_btn[0] = ($urandom_range(0, 47) == 0);
            i_btn[1] = ($urandom_range(0, 63) == 0);
            i_btn[2] = ($urandom_range(0, 127) == 0);
            i_btn[3] = ($urandom_range(0, 1) == 0);
            cfg_if.cfg_ready = ($urandom_range(0, 3) != 0);
            i_wr_en = ($urandom_range(0, 15) == 0);
            i_wr_addr = 2'($urandom_range(0, 3));
            i_wr_data = {5'($urandom_range(0, 3)), 7'($urandom)};
            clk_step();
            checks++;
            if (dut_snap() !== mdl_snap()) begin
                errors++;
                $display("FAIL rand_state c=%0d got %h want %h",
                         c, dut_snap(), mdl_snap());
            end
            checks++;
            if (act_tick !== m_tick) begin
                errors++;
                $display("FAIL rand_tick c=%0d got %b want %b",
                         c, act_tick, m_tick);
            end
        end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_basic();
        test_dwell_zero();
        test_ready_stall();
        test_pause();
        test_restart_skip();
        test_enable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter NB_PRESCALE, default 24: tick period is 2**NB_PRESCALE clock cycles.
REQ-002 Parameter NB_DWELL, default 5: width of per-step dwell field, in ticks.
REQ-003 Parameter N_STEPS, default 4: program table depth, a power of two.
REQ-004 clock  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 i_enable  in  1  global run enable; low freezes all state, prescaler and handshake outputs.
REQ-006 i_btn  in  4  raw buttons: [0] start/pause, [1] skip, [2] restart, [3] unused/ignored.
REQ-007 i_wr_en  in  1  program-table write strobe.
REQ-008 i_wr_addr  in  log2(N_STEPS)  table entry index.
REQ-009 i_wr_data  in  7+NB_DWELL  fields: {dwell, speed[1:0], dir, mode, color[2:0]}.
REQ-010 o_cfg_color/o_cfg_mode/o_cfg_dir/o_cfg_speed  out  3/1/1/2  configuration to the shift-LED datapath.
REQ-011 o_cfg_valid  out  1  configuration offered; i_cfg_ready  in  1  datapath accepts it.
REQ-012 o_state  out  2  FSM state; o_step  out  log2(N_STEPS)  current step; o_tick  out  1  one-cycle tick pulse.

Function
REQ-013 Buttons SHALL be rising-edge detected (registered previous value); only edges act, one cycle after the press is sampled.
REQ-014 FSM states SHALL be IDLE=0, LOAD=1, RUN=2, PAUSE=3.
REQ-015 IDLE: start edge -> LOAD with step=0; other buttons ignored.
REQ-016 LOAD: on entry, cfg outputs SHALL be registered from table[step]; o_cfg_valid=1 and cfg outputs stable until i_cfg_ready=1 while valid.
REQ-017 LOAD handshake: cycle with valid&ready -> RUN next cycle, o_cfg_valid=0, dwell counter loaded, prescaler cleared.
REQ-018 Dwell value 0 SHALL mean 2**NB_DWELL ticks.
REQ-019 RUN: prescaler increments each cycle; o_tick=1 when it equals all-ones; each tick decrements the dwell counter.
REQ-020 RUN: a tick with dwell counter==1 -> step+1 (wrap N_STEPS-1 -> 0) and LOAD.
REQ-021 RUN: skip edge -> step+1 (wrap) and LOAD immediately, discarding remaining dwell.
REQ-022 RUN: start/pause edge -> PAUSE; prescaler and dwell counter hold; PAUSE: start/pause edge -> RUN, resuming counts.
REQ-023 Restart edge in any state except IDLE -> LOAD with step=0, aborting any pending handshake (o_cfg_valid drops one cycle, reasserts with step-0 data).
REQ-024 Simultaneous events priority: restart > start/pause > skip > dwell expiry.
REQ-025 Table writes SHALL be accepted in every state; a write takes effect next cycle and never alters an already-captured cfg output.
REQ-026 i_enable=0 SHALL freeze FSM, counters, step and button-edge history; o_tick=0.

Reset
REQ-027 On reset: state IDLE, step 0, o_cfg_valid 0, o_tick 0, prescaler and dwell counter 0, edge history 0.
REQ-028 On reset: cfg outputs color=3'b001, mode=0, dir=0, speed=0; every table entry = same fields with dwell=4.
REQ-029 Reset asserted mid-LOAD or mid-RUN SHALL drop o_cfg_valid the same cycle (asynchronous).

Structure
REQ-030 Package led_seq_pkg SHALL hold state encoding, entry field offsets/widths, default table entry.
REQ-031 Sub-module btn_edge (4-bit registered rising-edge detector with enable) SHALL be instantiated once.

Verification (bench NB_PRESCALE=2, N_STEPS=4, NB_DWELL=5, i_cfg_ready=1 unless stated)
REQ-032 Reset then start edge -> LOAD, o_cfg_valid=1 for 1 cycle with color=001, dwell=4 -> RUN; 16 cycles later step=1.
REQ-033 Write entry 3 dwell=0, run to step 3 -> step 3 lasts 32 ticks (128 cycles), then step wraps to 0.
REQ-034 Hold i_cfg_ready=0 for 10 cycles in LOAD -> o_cfg_valid stays 1, cfg stable, no step change; ready=1 -> RUN next cycle.
REQ-035 Pause after 2 ticks of step 0, wait 50 cycles, resume -> step 0 ends exactly 2 ticks (8 cycles) later.
REQ-036 Restart and skip edges same cycle during RUN at step 2 -> LOAD step 0, not step 3.
REQ-037 i_enable=0 for 20 cycles in RUN with a start edge during it -> counters, state unchanged; no PAUSE.
